// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit; tracks in-flight destination tags EX..WB internally.
// stall is combinational from ID; ex_fwd_sel/ex_valid register on issue; mem_wait freezes all state.
module fwd_hazard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SELW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NUM_SRC*AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic [AW-1:0]           id_dst_addr,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    flush,
  input  logic                    mem_wait,
  output logic                    stall,
  output logic [NUM_SRC*SELW-1:0] ex_fwd_sel,
  output logic                    ex_valid,
  output logic [CNT_W-1:0]        stall_cnt
);

  // The WB entry retires into a write-before-read register file, so only
  // entries 1..DEPTH-1 can ever produce a match and need storage.
  logic [DEPTH-1:1] e_valid;
  logic [DEPTH-1:1] e_wr;
  logic [DEPTH-1:1] e_ld;
  logic [AW-1:0]    e_dst [1:DEPTH-1];

  logic [NUM_SRC-1:0]      src_haz;
  logic [NUM_SRC*SELW-1:0] sel_next;
  logic                    hazard;
  logic                    issue;

  always_comb begin
    src_haz  = '0;
    sel_next = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // Oldest first so the youngest matching entry overwrites the result.
      for (int i = DEPTH-1; i >= 1; i--) begin
        if (e_valid[i] && e_wr[i] && id_src_used[k] &&
            id_src_addr[k*AW +: AW] != '0 &&
            e_dst[i] == id_src_addr[k*AW +: AW]) begin
          if (e_ld[i] && (i < 1 + LOAD_LAT)) begin
            src_haz[k]                 = 1'b1;
            sel_next[k*SELW +: SELW]   = '0;
          end else begin
            src_haz[k]                 = 1'b0;
            sel_next[k*SELW +: SELW]   = SELW'(i);
          end
        end
      end
    end
  end

  assign hazard = id_valid && !flush && (|src_haz);
  assign stall  = hazard || mem_wait;
  assign issue  = id_valid && !flush && !hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid    <= '0;
      e_wr       <= '0;
      e_ld       <= '0;
      for (int i = 1; i <= DEPTH-1; i++) e_dst[i] <= '0;
      ex_fwd_sel <= '0;
      ex_valid   <= 1'b0;
      stall_cnt  <= '0;
    end else if (!mem_wait) begin
      for (int i = DEPTH-1; i >= 2; i--) begin
        e_valid[i] <= e_valid[i-1];
        e_wr[i]    <= e_wr[i-1];
        e_ld[i]    <= e_ld[i-1];
        e_dst[i]   <= e_dst[i-1];
      end
      if (issue) begin
        e_valid[1] <= 1'b1;
        e_wr[1]    <= id_reg_write && (id_dst_addr != '0);
        e_ld[1]    <= id_mem_read;
        e_dst[1]   <= id_dst_addr;
        ex_fwd_sel <= sel_next;
        ex_valid   <= 1'b1;
      end else begin
        e_valid[1] <= 1'b0;
        e_wr[1]    <= 1'b0;
        e_ld[1]    <= 1'b0;
        e_dst[1]   <= '0;
        ex_fwd_sel <= '0;
        ex_valid   <= 1'b0;
      end
      if (hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two instances (default, and DEPTH=4/LOAD_LAT=2) driven by directed vectors.
module tb_fwd_hazard_unit;

  logic clk;
  logic a_rst_n, a_valid, a_rw, a_mr, a_fl, a_mw, a_stall, a_ev;
  logic [9:0] a_src;
  logic [1:0] a_used;
  logic [4:0] a_dst;
  logic [3:0] a_sel;
  logic [15:0] a_cnt;
  logic b_rst_n, b_valid, b_rw, b_mr, b_fl, b_mw, b_stall, b_ev;
  logic [9:0] b_src;
  logic [1:0] b_used;
  logic [4:0] b_dst;
  logic [3:0] b_sel;
  logic [15:0] b_cnt;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(a_rst_n), .id_valid(a_valid), .id_src_addr(a_src),
    .id_src_used(a_used), .id_dst_addr(a_dst), .id_reg_write(a_rw),
    .id_mem_read(a_mr), .flush(a_fl), .mem_wait(a_mw), .stall(a_stall),
    .ex_fwd_sel(a_sel), .ex_valid(a_ev), .stall_cnt(a_cnt)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .id_valid(b_valid), .id_src_addr(b_src),
    .id_src_used(b_used), .id_dst_addr(b_dst), .id_reg_write(b_rw),
    .id_mem_read(b_mr), .flush(b_fl), .mem_wait(b_mw), .stall(b_stall),
    .ex_fwd_sel(b_sel), .ex_valid(b_ev), .stall_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          d;
    logic        es;
    logic        ev;
    logic [3:0]  esel;
    logic [15:0] ecnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation, sample the named instance mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.d) begin
        chk(e.nm, "stall", {15'd0, a_stall}, {15'd0, e.es});
        chk(e.nm, "ex_valid", {15'd0, a_ev}, {15'd0, e.ev});
        chk(e.nm, "ex_fwd_sel", {12'd0, a_sel}, {12'd0, e.esel});
        chk(e.nm, "stall_cnt", a_cnt, e.ecnt);
      end else begin
        chk(e.nm, "stall", {15'd0, b_stall}, {15'd0, e.es});
        chk(e.nm, "ex_valid", {15'd0, b_ev}, {15'd0, e.ev});
        chk(e.nm, "ex_fwd_sel", {12'd0, b_sel}, {12'd0, e.esel});
        chk(e.nm, "stall_cnt", b_cnt, e.ecnt);
      end
    end
  end

  task automatic cyc(input bit d, input bit rst, input bit v, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] used, input logic [4:0] dst, input bit rw, input bit mr,
                     input bit fl, input bit mw, input bit es, input bit ev,
                     input logic [3:0] esel, input logic [15:0] ecnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (!d) begin
      a_rst_n = rst; a_valid = v; a_src = {s1, s0}; a_used = used; a_dst = dst;
      a_rw = rw; a_mr = mr; a_fl = fl; a_mw = mw;
    end else begin
      b_rst_n = rst; b_valid = v; b_src = {s1, s0}; b_used = used; b_dst = dst;
      b_rw = rw; b_mr = mr; b_fl = fl; b_mw = mw;
    end
    e.d = d; e.es = es; e.ev = ev; e.esel = esel; e.ecnt = ecnt; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    clk = 1'b0;
    a_rst_n = 1'b0; a_valid = 1'b0; a_src = '0; a_used = '0; a_dst = '0;
    a_rw = 1'b0; a_mr = 1'b0; a_fl = 1'b0; a_mw = 1'b0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_src = '0; b_used = '0; b_dst = '0;
    b_rw = 1'b0; b_mr = 1'b0; b_fl = 1'b0; b_mw = 1'b0;

    // Reset state: stall follows mem_wait
    cyc(0,0, 0,0,0,2'b00,0,0,0,0,1, 1,0,4'h0,0,"rst_a_mw");
    cyc(1,0, 0,0,0,2'b00,0,0,0,0,0, 0,0,4'h0,0,"rst_b");

    // ALU back-to-back
    cyc(0,1, 1,0,0,2'b00,5,1,0,0,0, 0,0,4'h0,0,"alu_i1");
    cyc(0,1, 1,5,0,2'b01,0,0,0,0,0, 0,1,4'h0,0,"alu_i2");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h1,0,"alu_sel");

    // Youngest wins, then distance 2
    cyc(0,1, 1,0,0,2'b00,3,1,0,0,0, 0,0,4'h0,0,"yw_i1");
    cyc(0,1, 1,0,0,2'b00,3,1,0,0,0, 0,1,4'h0,0,"yw_i2");
    cyc(0,1, 1,0,3,2'b10,0,0,0,0,0, 0,1,4'h0,0,"yw_i3");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h4,0,"yw_sel1");
    cyc(0,1, 1,0,0,2'b00,3,1,0,0,0, 0,0,4'h0,0,"d2_i1");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h0,0,"d2_nop");
    cyc(0,1, 1,0,3,2'b10,0,0,0,0,0, 0,0,4'h0,0,"d2_i3");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h8,0,"d2_sel2");

    // Load-use: one bubble, both selects 2
    cyc(0,1, 1,0,0,2'b00,7,1,1,0,0, 0,0,4'h0,0,"lu_lw");
    cyc(0,1, 1,7,7,2'b11,9,1,0,0,0, 1,1,4'h0,0,"lu_stall");
    cyc(0,1, 1,7,7,2'b11,9,1,0,0,0, 0,0,4'h0,1,"lu_issue");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'hA,1,"lu_sel");

    // r0 never matches; unused source never forwards
    cyc(0,1, 1,0,0,2'b00,0,1,0,0,0, 0,0,4'h0,1,"r0_wr");
    cyc(0,1, 1,0,0,2'b11,0,0,0,0,0, 0,1,4'h0,1,"r0_rd");
    cyc(0,1, 1,0,0,2'b00,4,1,0,0,0, 0,1,4'h0,1,"un_prod");
    cyc(0,1, 1,0,4,2'b01,0,0,0,0,0, 0,1,4'h0,1,"un_rd");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h0,1,"un_sel");

    // mem_wait freezes a load-use hazard for three cycles
    cyc(0,1, 1,0,0,2'b00,7,1,1,0,0, 0,0,4'h0,1,"mw_lw");
    for (int n = 0; n < 3; n++)
      cyc(0,1, 1,7,7,2'b11,9,1,0,0,1, 1,1,4'h0,1,"mw_hold");
    cyc(0,1, 1,7,7,2'b11,9,1,0,0,0, 1,1,4'h0,1,"mw_rel_stall");
    cyc(0,1, 1,7,7,2'b11,9,1,0,0,0, 0,0,4'h0,2,"mw_issue");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'hA,2,"mw_sel");

    // Flush during hazard: no stall, bubble, no count
    cyc(0,1, 1,0,0,2'b00,7,1,1,0,0, 0,0,4'h0,2,"fl_lw");
    cyc(0,1, 1,7,7,2'b11,9,1,0,1,0, 0,1,4'h0,2,"fl_add");
    cyc(0,1, 0,0,0,2'b00,0,0,0,0,0, 0,0,4'h0,2,"fl_bubble");

    // DEPTH=4, LOAD_LAT=2: two stall cycles then select 3
    cyc(1,1, 1,0,0,2'b00,2,1,1,0,0, 0,0,4'h0,0,"p_lw");
    cyc(1,1, 1,2,0,2'b01,6,1,0,0,0, 1,1,4'h0,0,"p_stall1");
    cyc(1,1, 1,2,0,2'b01,6,1,0,0,0, 1,0,4'h0,1,"p_stall2");
    cyc(1,1, 1,2,0,2'b01,6,1,0,0,0, 0,0,4'h0,2,"p_issue");
    cyc(1,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h3,2,"p_sel3");

    // Asynchronous reset mid-sequence discards in-flight tags
    cyc(1,1, 1,0,0,2'b00,2,1,0,0,0, 0,0,4'h0,2,"r_wr");
    cyc(1,1, 1,2,0,2'b01,0,0,0,0,0, 0,1,4'h0,2,"r_rd");
    cyc(1,0, 0,0,0,2'b00,0,0,0,0,0, 0,0,4'h0,0,"r_async");
    cyc(1,1, 1,2,0,2'b01,0,0,0,0,0, 0,0,4'h0,0,"r_post_rd");
    cyc(1,1, 0,0,0,2'b00,0,0,0,0,0, 0,1,4'h0,0,"r_post_sel");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
